alu_uart_ctrl: RTL and testbench



---
 rtl/alu_uart_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_uart_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl.sv
// Byte-stream front end: collects operand A, operand B and opcode from the UART receiver,
// drives the ALU, and returns the result to the UART transmitter. Optional opcode filter: ALU_CTRL_OPCODE_CHECK_EN.
module alu_uart_ctrl #(
  parameter int NB_OPERANDO    = 8,
  parameter int NB_OPCODE      = 6,
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NB_OPERANDO-1:0] rx_data,
  input  logic                   rx_done,
  output logic [NB_OPERANDO-1:0] alu_a,
  output logic [NB_OPERANDO-1:0] alu_b,
  output logic [NB_OPCODE-1:0]   alu_op,
  input  logic [NB_OPERANDO-1:0] alu_result,
  output logic [NB_OPERANDO-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout,
  output logic                   op_error
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  localparam bit                    TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [NB_TIMEOUT-1:0]   cnt, cnt_nxt;
  logic                    in_frame;
  logic                    expired;
  logic                    timeout_hit;
  logic                    op_valid;
  logic                    op_reject;
  logic                    drop;

`ifdef ALU_CTRL_OPCODE_CHECK_EN
  localparam logic [7:0] LEGAL_OPS [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  // Whole byte is compared, so any set upper bit rejects the opcode.
  function automatic logic opcode_ok(input logic [NB_OPERANDO-1:0] b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b == NB_OPERANDO'(LEGAL_OPS[i])) ok = 1'b1;
    end
    return ok;
  endfunction

  assign op_valid = opcode_ok(rx_data);
`else
  assign op_valid = 1'b1;
`endif

  assign in_frame = (state == WAIT_B) || (state == WAIT_OP);
  assign expired  = TO_EN && (cnt == CNT_LAST);
  assign drop     = rx_done && ((state == EXEC) || (state == SEND) || (state == WAIT_TX));

  always_comb begin
    state_nxt   = state;
    op_reject   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      WAIT_A:  if (rx_done) state_nxt = WAIT_B;
      WAIT_B: begin
        if (rx_done) begin
          state_nxt = WAIT_OP;
        end else if (expired) begin
          state_nxt   = WAIT_A;
          timeout_hit = 1'b1;
        end
      end
      WAIT_OP: begin
        if (rx_done) begin
          if (op_valid) state_nxt = EXEC;
          else          op_reject = 1'b1;
        end else if (expired) begin
          state_nxt   = WAIT_A;
          timeout_hit = 1'b1;
        end
      end
      EXEC:    state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (tx_done) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  // Idle counter only runs while a partial frame waits for its next byte; it saturates.
  always_comb begin
    cnt_nxt = '0;
    if (in_frame && !rx_done && !timeout_hit) begin
      cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_A;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      op_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx_start <= (state_nxt == SEND);
      busy     <= (state_nxt != WAIT_A);
      overrun  <= drop;
      timeout  <= timeout_hit;
      op_error <= op_reject;
      if (state == WAIT_A && rx_done)              alu_a   <= rx_data;
      if (state == WAIT_B && rx_done)              alu_b   <= rx_data;
      if (state == WAIT_OP && rx_done && op_valid) alu_op  <= rx_data[NB_OPCODE-1:0];
      if (state == EXEC)                           tx_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed frames from the test plan plus randomized
// frames scored against a frame-level reference (bytes in -> result byte out).
module tb_alu_uart_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_a, alu_b, alu_result, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, tx_done, busy, overrun, timeout, op_error;

  int n_vec = 0;
  int n_err = 0;
  int exp_starts = 0, exp_overruns = 0, exp_timeouts = 0, exp_operrs = 0;
  int obs_starts = 0, obs_overruns = 0, obs_timeouts = 0, obs_operrs = 0;

  always #5 clk = ~clk;

  alu_uart_ctrl #(
    .NB_OPERANDO(8), .NB_OPCODE(6), .NB_TIMEOUT(24), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .overrun(overrun), .timeout(timeout), .op_error(op_error)
  );

  // Behavioural ALU: MIPS-style funct codes, unsupported codes return 0.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) obs_starts++;
      if (overrun)  obs_overruns++;
      if (timeout)  obs_timeouts++;
      if (op_error) obs_operrs++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic advance(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = $urandom_range(0, 255);
  endtask

  // Called in the cycle after the opcode byte was sampled.
  task automatic finish_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input int dly, input bit orun);
    logic [7:0] exp;
    exp = alu_fn(a, b, op[5:0]);
    @(negedge clk);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, op & 8'h3F);
    check("start_early", tx_start, 0);
    check("busy_exec", busy, 1);
    advance(1);
    @(negedge clk);
    check("tx_start", tx_start, 1);
    check("tx_data", tx_data, exp);
    exp_starts++;
    advance(1);
    if (orun) begin
      send_byte(8'h77);
      exp_overruns++;
      @(negedge clk);
      check("overrun", overrun, 1);
      check("tx_data_orun", tx_data, exp);
      check("busy_orun", busy, 1);
    end
    repeat (dly) begin
      @(negedge clk);
      check("tx_hold", tx_data, exp);
      advance(1);
    end
    tx_done = 1'b1;
    advance(1);
    tx_done = 1'b0;
    @(negedge clk);
    check("busy_idle", busy, 0);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int gap, input int dly, input bit orun);
    send_byte(a);
    advance(gap);
    send_byte(b);
    advance(gap);
    send_byte(op);
    finish_frame(a, b, op, dly, orun);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [8];
    logic [7:0] a, b, op;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    advance(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_flags", {tx_start, busy, overrun, timeout, op_error}, 0);

    // ADD, SUB wrap, NOR back-to-back
    do_frame(8'h05, 8'h03, 8'h20, 0, 1, 0);
    do_frame(8'h03, 8'h05, 8'h22, 1, 0, 0);
    do_frame(8'hF0, 8'h0C, 8'h27, 0, 2, 0);

    // Timeout after a lone A byte
    send_byte(8'h11);
    advance(TO - 1);
    @(negedge clk);
    check("to_pending", timeout, 0);
    check("to_busy", busy, 1);
    advance(1);
    @(negedge clk);
    check("timeout", timeout, 1);
    check("to_idle", busy, 0);
    exp_timeouts++;

    // Byte in the expiry cycle is accepted instead
    send_byte(8'h11);
    advance(TO - 1);
    send_byte(8'h22);
    @(negedge clk);
    check("to_win", timeout, 0);
    check("to_win_b", alu_b, 8'h22);
    send_byte(8'h20);
    finish_frame(8'h11, 8'h22, 8'h20, 0, 0);

    // Overrun during WAIT_TX, then AND frame
    do_frame(8'h0A, 8'h0B, 8'h26, 0, 1, 1);
    do_frame(8'h02, 8'h02, 8'h24, 0, 0, 0);

`ifdef ALU_CTRL_OPCODE_CHECK_EN
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h3F);
    @(negedge clk);
    check("op_error", op_error, 1);
    check("op_kept", alu_op, 6'h24);
    check("op_busy", busy, 1);
    exp_operrs++;
    advance(1);
    @(negedge clk);
    check("op_no_start", tx_start, 0);
    send_byte(8'h25);
    finish_frame(8'h01, 8'h01, 8'h25, 0, 0);
`else
    do_frame(8'h01, 8'h01, 8'h3F, 0, 0, 0);
    check("op_error_tied", op_error, 0);
`endif

    // Reset mid-frame after B
    send_byte(8'h44);
    send_byte(8'h55);
    reset = 1'b1;
    advance(1);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_regs", {alu_a, alu_b, 2'b00, alu_op, tx_data}, 0);
    check("mrst_flags", {tx_start, busy, overrun, timeout, op_error}, 0);
    do_frame(8'h08, 8'h02, 8'h02, 0, 0, 0);

    // Randomized frames
    for (int i = 0; i < 150; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      op = ops[$urandom_range(0, 7)];
`ifndef ALU_CTRL_OPCODE_CHECK_EN
      if ($urandom_range(0, 3) == 0) op = $urandom_range(0, 255);
`endif
      do_frame(a, b, op, $urandom_range(0, 4), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    advance(3);
    check("n_tx_start", obs_starts, exp_starts);
    check("n_overrun", obs_overruns, exp_overruns);
    check("n_timeout", obs_timeouts, exp_timeouts);
    check("n_op_error", obs_operrs, exp_operrs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
